// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB update controller: queue entry layout
// and the sequential-PC helper used for fall-through addresses.
package btb_pkg;

  localparam int BTB_ADDR_LEN        = 32;
  localparam int DEFAULT_QUEUE_DEPTH = 4;

  typedef struct packed {
    logic [BTB_ADDR_LEN-1:0] pc;
    logic [BTB_ADDR_LEN-1:0] target;
  } upd_entry_t;

  function automatic logic [BTB_ADDR_LEN-1:0] seq_pc(input logic [BTB_ADDR_LEN-1:0] pc);
    return pc + BTB_ADDR_LEN'(4);
  endfunction

endpackage

// File: rtl/btb_update_ctrl_sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones, cleared by the
// asynchronous active-low reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/btb_update_ctrl.sv
// Branch resolution compare, flush/redirect generation, and a coalescing BTB
// write queue drained one entry per cycle, plus saturating statistics.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH,
  parameter int CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ex_valid,
  input  logic [31:0]                    ex_pc,
  input  logic                           ex_taken,
  input  logic [31:0]                    ex_target,
  input  logic                           ex_pred_valid,
  input  logic [31:0]                    ex_pred_target,
  input  logic                           btb_hold,
  output logic                           flush,
  output logic [31:0]                    redirect_pc,
  output logic                           btb_update,
  output logic [31:0]                    btb_update_pc,
  output logic [31:0]                    btb_update_target,
  output logic [$clog2(QUEUE_DEPTH):0]   q_count,
  output logic [CNT_W-1:0]               branch_cnt,
  output logic [CNT_W-1:0]               mispredict_cnt,
  output logic [CNT_W-1:0]               drop_cnt
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CW    = PTR_W + 1;

  upd_entry_t      queue_reg [QUEUE_DEPTH];
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CW-1:0]    count_reg, count_next;

  logic        btb_update_reg;
  upd_entry_t  out_reg;

  logic [31:0] actual_pc, pred_pc;
  logic        need, deq, full, hit, push, drop;
  logic [PTR_W-1:0] hit_idx;

  // Resolution
  assign actual_pc   = ex_taken ? ex_target : seq_pc(ex_pc);
  assign pred_pc     = ex_pred_valid ? ex_pred_target : seq_pc(ex_pc);
  assign flush       = ex_valid && (actual_pc != pred_pc);
  assign redirect_pc = actual_pc;

  assign need = ex_valid && ex_taken && (!ex_pred_valid || (ex_pred_target != ex_target));
  assign deq  = (count_reg != '0) && !btb_hold;
  assign full = (count_reg == CW'(QUEUE_DEPTH));

  // Scan oldest to youngest so the last match (youngest) wins; the head is
  // skipped when it is leaving this cycle, since its write is already committed.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int k = 0; k < QUEUE_DEPTH; k++) begin
      idx = head_reg + PTR_W'(k);
      if ((CW'(k) < count_reg) && !(deq && (k == 0)) && (queue_reg[idx].pc == ex_pc)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  assign push = need && !hit && (!full || deq);
  assign drop = need && !hit && full && !deq;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (deq)  head_next = head_reg + PTR_W'(1);
    if (push) tail_next = tail_reg + PTR_W'(1);
    count_next = count_reg + CW'(push) - CW'(deq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // A coalesce rewrites pc with the same value, so one write port serves both cases.
  generate
    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
      logic wr_en;
      assign wr_en = (push && (tail_reg == PTR_W'(gi))) ||
                     (need && hit && (hit_idx == PTR_W'(gi)));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          queue_reg[gi] <= '0;
        end else if (wr_en) begin
          queue_reg[gi].pc     <= ex_pc;
          queue_reg[gi].target <= ex_target;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_update_reg <= 1'b0;
      out_reg        <= '0;
    end else begin
      btb_update_reg <= deq;
      if (deq) out_reg <= queue_reg[head_reg];
    end
  end

  assign btb_update        = btb_update_reg;
  assign btb_update_pc     = out_reg.pc;
  assign btb_update_target = out_reg.target;
  assign q_count           = count_reg;

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ex_valid),
    .count (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispredict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush),
    .count (mispredict_cnt)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop),
    .count (drop_cnt)
  );

endmodule
